// File: rtl/adder_slice_sequencer.sv
// rtl/adder_slice_sequencer.sv - XLEN-bit add/sub sequenced through one external SLICE-bit adder
// Optional: define ADDER_SEQ_B2B_EN to accept the next request in the response cycle.
module adder_slice_sequencer #(
   parameter int XLEN  = 32,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_op,
   input  logic [XLEN-1:0]  req_a,
   input  logic [XLEN-1:0]  req_b,
   output logic [SLICE-1:0] adder_a,
   output logic [SLICE-1:0] adder_b,
   output logic             adder_cin,
   input  logic [SLICE-1:0] adder_sum,
   input  logic             adder_cout,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [XLEN-1:0]  rsp_result,
   output logic             rsp_carry,
   output logic             rsp_overflow
);
   localparam int NSLICE = XLEN / SLICE;
   localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state;
   logic [XLEN-1:0] a_reg;
   logic [XLEN-1:0] b_reg;
   logic [XLEN-1:0] res_reg;
   logic [XLEN-1:0] res_next;
   logic            carry_reg;
   logic [CW-1:0]   cnt;
   logic            take;
   logic            ovf_next;

   // Operand shift registers drain to zero and carry_reg is cleared on the last
   // slice, so the adder ports read registers directly and are zero outside EXEC.
   assign adder_a   = a_reg[SLICE-1:0];
   assign adder_b   = b_reg[SLICE-1:0];
   assign adder_cin = carry_reg;

`ifdef ADDER_SEQ_B2B_EN
   assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
`else
   assign req_ready = (state == IDLE);
`endif
   assign take = req_valid && req_ready;

   always_comb begin
      res_next = res_reg >> SLICE;
      res_next[XLEN-1 -: SLICE] = adder_sum;
   end

   assign ovf_next = (a_reg[SLICE-1] == b_reg[SLICE-1]) && (adder_sum[SLICE-1] != a_reg[SLICE-1]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         a_reg        <= '0;
         b_reg        <= '0;
         res_reg      <= '0;
         carry_reg    <= 1'b0;
         cnt          <= '0;
         rsp_valid    <= 1'b0;
         rsp_result   <= '0;
         rsp_carry    <= 1'b0;
         rsp_overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: ;
            EXEC: begin
               a_reg     <= a_reg >> SLICE;
               b_reg     <= b_reg >> SLICE;
               res_reg   <= res_next;
               carry_reg <= adder_cout;
               cnt       <= cnt + 1'b1;
               if (cnt == LAST) begin
                  carry_reg    <= 1'b0;
                  cnt          <= '0;
                  state        <= RESP;
                  rsp_valid    <= 1'b1;
                  rsp_result   <= res_next;
                  rsp_carry    <= adder_cout;
                  rsp_overflow <= ovf_next;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // Subtract is A + ~B + 1: invert B once here and seed the carry with the op.
         if (take) begin
            a_reg     <= req_a;
            b_reg     <= req_op ? ~req_b : req_b;
            carry_reg <= req_op;
            cnt       <= '0;
            state     <= EXEC;
         end
      end
   end
endmodule

// File: tb/tb_adder_slice_sequencer.sv
// tb/tb_adder_slice_sequencer.sv - randomized self-checking bench for adder_slice_sequencer
module tb_adder_slice_sequencer;
   localparam int XLEN   = 32;
   localparam int SLICE  = 16;
   localparam int NSLICE = XLEN / SLICE;
`ifdef ADDER_SEQ_B2B_EN
   localparam int SPACING = NSLICE + 1;
   localparam int REL_CYC = 1;
`else
   localparam int SPACING = NSLICE + 2;
   localparam int REL_CYC = 2;
`endif

   typedef struct {
      logic [XLEN-1:0] res;
      logic            c;
      logic            v;
      int              cyc;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_op = 1'b0;
   logic [XLEN-1:0]  req_a = '0;
   logic [XLEN-1:0]  req_b = '0;
   logic             rsp_ready = 1'b0;
   logic             req_ready;
   logic [SLICE-1:0] adder_a;
   logic [SLICE-1:0] adder_b;
   logic             adder_cin;
   logic [SLICE-1:0] adder_sum;
   logic             adder_cout;
   logic             rsp_valid;
   logic [XLEN-1:0]  rsp_result;
   logic             rsp_carry;
   logic             rsp_overflow;

   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   bit   rnd_bp = 1'b0;
   exp_t exp_q[$];
   int   rise_q[$];

   adder_slice_sequencer #(.XLEN(XLEN), .SLICE(SLICE)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
      .adder_sum(adder_sum), .adder_cout(adder_cout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow)
   );

   // The external combinational slice adder.
   assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + (SLICE+1)'(adder_cin);

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic exp_t model(input logic op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int c);
      exp_t   e;
      longint lim = 64'sh8000_0000;
      longint sa  = longint'($signed(a));
      longint sb  = longint'($signed(b));
      longint ua  = longint'({32'd0, a});
      longint ub  = longint'({32'd0, b});
      longint sr  = op ? sa - sb : sa + sb;
      e.res = sr[XLEN-1:0];
      e.c   = op ? (ua >= ub) : (ua + ub >= 64'sh1_0000_0000);
      e.v   = (sr >= lim) || (sr < -lim);
      e.cyc = c;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_bp) rsp_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      bit fire = 1'b0;
      int n = 0;
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      while (!fire && n < 40) begin
         @(negedge clk);
         fire = req_ready;
         n++;
         step();
      end
      req_valid = 1'b0;
      req_a = $urandom;
      req_b = $urandom;
      chk("accept_timeout", 64'(fire), 1);
   endtask

   task automatic wait_rsp(output logic [XLEN-1:0] res);
      bit seen = 1'b0;
      int n = 0;
      res = '0;
      while (!seen && n < 40) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            seen = 1'b1;
            res = rsp_result;
         end
         n++;
         step();
      end
      chk("rsp_timeout", 64'(seen), 1);
   endtask

   // Scoreboard: handshake capture, response ordering, latency and backpressure stability.
   initial begin
      exp_t e;
      bit prev_valid;
      bit hold;
      logic [XLEN+1:0] h;
      prev_valid = 1'b0;
      hold = 1'b0;
      h = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            exp_q.delete();
            prev_valid = 1'b0;
            hold = 1'b0;
         end else begin
            if (hold) chk("bp_stable", {rsp_valid, rsp_result, rsp_carry, rsp_overflow}, {1'b1, h});
            if (rsp_valid) chk("resp_adder_zero", {adder_a, adder_b, adder_cin}, 0);
            if (rsp_valid && !prev_valid) begin
               rise_q.push_back(cyc);
               chk("rsp_expected", 64'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) chk("latency", 64'(cyc - exp_q[0].cyc), NSLICE + 1);
            end
            if (rsp_valid && !rsp_ready) chk("bp_req_ready", req_ready, 0);
            if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("result", rsp_result, e.res);
               chk("carry", rsp_carry, e.c);
               chk("overflow", rsp_overflow, e.v);
            end
            if (req_valid && req_ready) exp_q.push_back(model(req_op, req_a, req_b, cyc));
            hold = rsp_valid && !rsp_ready;
            h = {rsp_result, rsp_carry, rsp_overflow};
            prev_valid = rsp_valid;
         end
      end
   end

   initial begin
      logic [XLEN-1:0] r;
      int t0;
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp", {rsp_result, rsp_carry, rsp_overflow}, 0);
      chk("rst_adder", {adder_a, adder_b, adder_cin}, 0);
      reset = 1'b1;
      rsp_ready = 1'b1;
      step();

      send(1'b0, 32'h0000FFFF, 32'h00000001);
      @(negedge clk);
      chk("s0_cin", adder_cin, 0);
      chk("s0_cout", adder_cout, 1);
      step();
      @(negedge clk);
      chk("s1_cin", adder_cin, 1);
      wait_rsp(r);
      chk("add_carry_res", r, 32'h00010000);

      send(1'b1, 32'd5, 32'd7);
      @(negedge clk);
      chk("sub_s0_b", adder_b, 16'hFFF8);
      chk("sub_s0_cin", adder_cin, 1);
      wait_rsp(r);
      chk("sub_res", r, 32'hFFFFFFFE);

      send(1'b0, 32'h7FFFFFFF, 32'h1);
      wait_rsp(r);
      send(1'b1, 32'h80000000, 32'h1);
      wait_rsp(r);

      rsp_ready = 1'b0;
      send(1'b1, $urandom, $urandom);
      step();
      step();
      req_valid = 1'b1; req_op = 1'b0; req_a = 32'd11; req_b = 32'd22;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", rsp_valid, 1);
         chk("bp_ready_low", req_ready, 0);
         step();
      end
      rsp_ready = 1'b1;
      t0 = cyc;
      send(1'b0, 32'd11, 32'd22);
      chk("release_accept", 64'(cyc - t0), REL_CYC);
      wait_rsp(r);
      chk("bp_next_res", r, 32'd33);

      send(1'b0, 32'hFFFFFFFF, 32'h1);
      step();
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_valid", rsp_valid, 0);
      chk("mid_rst_rsp", {rsp_result, rsp_carry, rsp_overflow}, 0);
      chk("mid_rst_adder", {adder_a, adder_b, adder_cin}, 0);
      chk("mid_rst_ready", req_ready, 1);
      step();
      step();
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_rsp_after_rst", rsp_valid, 0);
         step();
      end
      send(1'b0, 32'd3, 32'd4);
      wait_rsp(r);
      chk("post_rst_res", r, 32'd7);

      rise_q.delete();
      for (int i = 0; i < 4; i++) send(1'b0, $urandom, $urandom);
      wait_rsp(r);
      chk("stream_count", 64'(rise_q.size()), 4);
      if (rise_q.size() == 4)
         for (int i = 1; i < 4; i++) chk("stream_spacing", 64'(rise_q[i] - rise_q[i-1]), SPACING);

      rnd_bp = 1'b1;
      for (int i = 0; i < 40; i++) send(1'($urandom_range(0, 1)), $urandom, $urandom);
      rnd_bp = 1'b0;
      rsp_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         step();
         n++;
      end
      chk("drain", 64'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end
endmodule
